// File: rtl/fp_div.sv
// IEEE-754 single-precision divider: result = dataA / dataB.
// Iterative radix-2 restoring divide, start/done handshake, one op in flight.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   start  : operand valid, sampled only in IDLE
//   dataA  : dividend, captured on accepted start
//   dataB  : divisor, captured on accepted start
//   busy   : high in DIV and ROUND
//   done   : one-cycle pulse, result valid
//   result : quotient, held until next done
module fp_div #(
    parameter logic [31:0] NAN_VALUE = 32'h7f800001,
    parameter int          QBITS     = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CW = $clog2(QBITS);
    localparam logic [CW-1:0] LAST = CW'(QBITS - 1);

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

    state_t             state;
    kind_t              kind;
    logic [CW-1:0]      cnt;
    logic [24:0]        rem;
    logic [23:0]        mb;
    logic [QBITS-1:0]   q;
    logic               sgn;
    logic signed [9:0]  exp_d;

    // operand classification at capture
    logic [7:0] ea, eb;
    logic       a_nan, a_inf, a_zero;
    logic       b_nan, b_inf, b_zero;
    kind_t      kind_n;

    assign ea     = dataA[30:23];
    assign eb     = dataB[30:23];
    assign a_nan  = (ea == 8'hff) && (dataA[22:0] != 23'd0);
    assign a_inf  = (ea == 8'hff) && (dataA[22:0] == 23'd0);
    assign a_zero = (ea == 8'h00);
    assign b_nan  = (eb == 8'hff) && (dataB[22:0] != 23'd0);
    assign b_inf  = (eb == 8'hff) && (dataB[22:0] == 23'd0);
    assign b_zero = (eb == 8'h00);

    always_comb begin
        kind_n = K_NORM;
        if (a_nan || b_nan)
            kind_n = K_NAN;
        else if ((a_inf && b_inf) || (a_zero && b_zero))
            kind_n = K_NAN;
        else if (a_inf || b_zero)
            kind_n = K_INF;
        else if (b_inf || a_zero)
            kind_n = K_ZERO;
    end

    // one restoring step; remainder before the step is < 2*mb
    logic        ge;
    logic [23:0] rsub;

    assign ge   = rem >= {1'b0, mb};
    assign rsub = ge ? 24'(rem - {1'b0, mb}) : rem[23:0];

    // normalise and round-to-nearest-even
    logic               hi, g, st;
    logic [23:0]        mant;
    logic [24:0]        sum;
    logic [22:0]        frac;
    logic signed [9:0]  e0, e1;
    logic [31:0]        norm_res;
    logic [31:0]        rnd_res;

    always_comb begin
        hi   = q[QBITS-1];
        mant = hi ? q[QBITS-1:2] : q[QBITS-2:1];
        g    = hi ? q[1] : q[0];
        st   = hi ? (q[0] | (rem != '0)) : (rem != '0);
        e0   = exp_d + (hi ? 10'sd127 : 10'sd126);
        sum  = {1'b0, mant} + {24'd0, g & (st | mant[0])};
        // on carry-out the sum is exactly 2.0, so the shifted fraction is zero
        frac = sum[24] ? sum[23:1] : sum[22:0];
        e1   = e0 + $signed({9'd0, sum[24]});
        if (e1 >= 10'sd255)
            norm_res = {sgn, 8'hff, 23'd0};
        else if (e1 <= 10'sd0)
            norm_res = {sgn, 31'd0};
        else
            norm_res = {sgn, e1[7:0], frac};
    end

    always_comb begin
        rnd_res = norm_res;
        case (kind)
            K_NAN:   rnd_res = NAN_VALUE;
            K_INF:   rnd_res = {sgn, 8'hff, 23'd0};
            K_ZERO:  rnd_res = {sgn, 31'd0};
            default: rnd_res = norm_res;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
            cnt    <= '0;
            rem    <= '0;
            mb     <= '0;
            q      <= '0;
            sgn    <= 1'b0;
            exp_d  <= '0;
            kind   <= K_NORM;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= DIV;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        rem   <= {1'b0, 1'b1, dataA[22:0]};
                        mb    <= {1'b1, dataB[22:0]};
                        q     <= '0;
                        sgn   <= dataA[31] ^ dataB[31];
                        exp_d <= $signed({2'b00, ea}) - $signed({2'b00, eb});
                        kind  <= kind_n;
                    end
                end
                DIV: begin
                    rem <= {rsub, 1'b0};
                    q   <= {q[QBITS-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= ROUND;
                end
                ROUND: begin
                    result <= rnd_res;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: vector table driven through a
// scoreboard queue, plus hand-written control sequences.
module tb_fp_div;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int compared   = 0;
    int mismatched = 0;
    int done_seen  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[$];

    fp_div dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .dataA  (dataA),
        .dataB  (dataB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // scoreboard: every done pulse pops one expected result
    always @(negedge clock) begin
        if (!reset && done) begin
            done_seen++;
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got result %h expected no done",
                         result);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check(e.name, result, e.exp);
            end
        end
    end

    // one operation; checks busy and the 28-cycle latency
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        int cyc;
        sb_t e;
        @(negedge clock);
        dataA = a;
        dataB = b;
        start = 1'b1;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
        @(posedge clock);
        cyc = 1;
        @(negedge clock);
        start = 1'b0;
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        while (!done && cyc < 60) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected 28",
                     name, cyc);
            void'(sbq.pop_back());
        end else begin
            check({name, "_lat"}, cyc, 28);
        end
    endtask

    initial begin
        vecs.push_back('{32'h41400000, 32'h41400000, 32'h3f800000, "12div12"});
        vecs.push_back('{32'h43100000, 32'h41400000, 32'h41400000, "144div12"});
        vecs.push_back('{32'hc1400000, 32'h3f000000, 32'hc1c00000, "m12divhalf"});
        vecs.push_back('{32'h3f800000, 32'h40400000, 32'h3eaaaaab, "1div3"});
        vecs.push_back('{32'h40000000, 32'h3f800000, 32'h40000000, "2div1"});
        vecs.push_back('{32'h3f800000, 32'h00000000, 32'h7f800000, "1div0"});
        vecs.push_back('{32'hbf800000, 32'h00000000, 32'hff800000, "m1div0"});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7f800001, "0div0"});
        vecs.push_back('{32'h7f800000, 32'h41400000, 32'h7f800000, "infdiv12"});
        vecs.push_back('{32'hff800000, 32'h40000000, 32'hff800000, "minfdiv2"});
        vecs.push_back('{32'h7f800000, 32'hff800000, 32'h7f800001, "infdivinf"});
        vecs.push_back('{32'h7f800001, 32'h41400000, 32'h7f800001, "nandiv12"});
        vecs.push_back('{32'h3f800000, 32'h7fc00000, 32'h7f800001, "1divnan"});
        vecs.push_back('{32'h41400000, 32'h7f800000, 32'h00000000, "12divinf"});
        vecs.push_back('{32'hbf800000, 32'hff800000, 32'h00000000, "m1divminf"});
        vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, "m0div2"});
        vecs.push_back('{32'h00400000, 32'h3f800000, 32'h00000000, "denormdiv1"});
        vecs.push_back('{32'h7f000000, 32'h3e800000, 32'h7f800000, "overflow"});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, "underflow"});

        // reset with start held high: reset must win
        reset = 1'b1;
        start = 1'b1;
        dataA = 32'h41400000;
        dataB = 32'h41400000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // vector table, back-to-back
        for (int i = 0; i < vecs.size(); i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // start pulsed while busy is ignored
        begin
            int cyc;
            sb_t e;
            @(negedge clock);
            dataA = 32'h41400000;
            dataB = 32'h41400000;
            start = 1'b1;
            e.exp  = 32'h3f800000;
            e.name = "busy_ign";
            sbq.push_back(e);
            @(posedge clock);
            cyc = 1;
            @(negedge clock);
            start = 1'b0;
            repeat (5) begin
                @(posedge clock);
                cyc++;
            end
            @(negedge clock);
            dataA = 32'h3f800000;
            dataB = 32'h00000000;
            start = 1'b1;
            @(posedge clock);
            cyc++;
            @(negedge clock);
            start = 1'b0;
            while (!done && cyc < 60) begin
                @(posedge clock);
                cyc++;
                @(negedge clock);
            end
            check("busy_ign_lat", cyc, 28);
            // pulse start during the DONE cycle: also ignored
            dataA = 32'h3f800000;
            dataB = 32'h00000000;
            start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            repeat (3) @(negedge clock);
            check("done_ign_busy", {31'd0, busy}, 32'd0);
            check("done_ign_hold", result, 32'h3f800000);
        end

        // reset during DIV cycle 10 aborts the operation
        begin
            int seen;
            @(negedge clock);
            dataA = 32'h3f800000;
            dataB = 32'h40400000;
            start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            repeat (10) @(posedge clock);
            @(negedge clock);
            check("abort_busy_pre", {31'd0, busy}, 32'd1);
            reset = 1'b1;
            @(posedge clock);
            @(negedge clock);
            reset = 1'b0;
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
            check("abort_result", result, 32'd0);
            seen = done_seen;
            repeat (40) @(negedge clock);
            check("abort_no_done", done_seen - seen, 0);
        end

        // recovers after abort
        do_op(32'h3f800000, 32'h40400000, 32'h3eaaaaab, "after_abort");

        repeat (5) @(negedge clock);
        check("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
